// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared 64-bit Y86 ALU (add/sub/and/xor) with flags.
// One cycle from accept to held result; accepts only while the result register is empty or draining.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zf,
  output logic             rsp_sf,
  output logic             rsp_of
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic               last_id;
  logic               can_load;
  logic               grant_id;
  logic               accept;
  logic [1:0]         sel_fun;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_of;

  assign rsp_valid = (state == FULL);
  assign can_load  = !rsp_valid || rsp_ready;

  // A lone requester wins outright; a tie goes to whoever was not served last.
  assign grant_id   = (req0_valid && req1_valid) ? !last_id : !req0_valid;
  assign req0_ready = !rst && req0_valid && can_load && (grant_id == 1'b0);
  assign req1_ready = !rst && req1_valid && can_load && (grant_id == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign sel_fun = grant_id ? req1_fun : req0_fun;
  assign sel_a   = grant_id ? req1_a   : req0_a;
  assign sel_b   = grant_id ? req1_b   : req0_b;

  always_comb begin
    alu_result = '0;
    alu_of     = 1'b0;
    case (sel_fun)
      2'd0: begin
        alu_result = sel_a + sel_b;
        alu_of     = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (alu_result[WIDTH-1] != sel_a[WIDTH-1]);
      end
      2'd1: begin
        alu_result = sel_a - sel_b;
        alu_of     = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) && (alu_result[WIDTH-1] != sel_a[WIDTH-1]);
      end
      2'd2:    alu_result = sel_a & sel_b;
      default: alu_result = sel_a ^ sel_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      last_id    <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_of     <= 1'b0;
    end else begin
      if (accept) begin
        last_id    <= grant_id;
        rsp_id     <= grant_id;
        rsp_result <= alu_result;
        rsp_zf     <= (alu_result == '0);
        rsp_sf     <= alu_result[WIDTH-1];
        rsp_of     <= alu_of;
      end
      case (state)
        EMPTY:   if (accept) state <= FULL;
        FULL:    if (rsp_ready && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 64-bit Y86 ALU (add/sub/and/xor) between two requesters, e.g. the execute stage and an address/stack-pointer update path. Requests use a valid/ready handshake. A round-robin arbiter grants one request per cycle. The granted operation is evaluated and captured, with condition codes, in a single-entry output register that has its own valid/ready handshake. The block gives the design one arbitration point and one flag source for all integer arithmetic.

## Interface
Parameters:
- WIDTH, 64, operand/result width; OF/SF use bit WIDTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_fun  in  2  0 add, 1 sub, 2 and, 3 xor (Y86 OPq ifun).
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_fun, req1_a, req1_b: same as the req0_* ports, for requester 1.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  requester that issued the held result.
- rsp_result  out  WIDTH  held result.
- rsp_zf, rsp_sf, rsp_of  out  1  zero, sign and signed-overflow flags of the held result.

## Operation
- Functions:
  - add: a+b, modulo 2^WIDTH.
  - sub: a-b, modulo 2^WIDTH.
  - and: a&b.
  - xor: a^b.
- Flags:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF for add = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - OF for sub = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - OF = 0 for and/xor.
  - Carry-out is discarded.
- Output register can load: can_load = !rsp_valid || rsp_ready.
- Arbitration is combinational and round-robin, using register last_id:
  - One valid requester: that requester is granted.
  - Both valid: grant goes to !last_id.
  - reqN_ready = grant==N && reqN_valid && can_load.
  - At most one ready is high per cycle.
- Accept: reqN_valid && reqN_ready. On accept, the output register loads result, flags and rsp_id=N, rsp_valid goes to 1, and last_id becomes N.
- last_id changes only on accept. Idle cycles and stalls keep the pointer.
- Drain without new accept: rsp_valid && rsp_ready with no accept in the same cycle sets rsp_valid to 0.
- Drain and accept in the same cycle: the new result loads, rsp_valid stays 1. This gives full throughput of one operation per cycle.
- Two-state FSM, derived from rsp_valid:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with rsp_ready high, or when rsp_ready is low.
  - FULL → EMPTY when rsp_ready is high and there is no accept.
- Requester obligations: hold fun, a and b stable while valid is high until ready. Valid must not drop before accept.
- Held rsp_* values stay stable while rsp_valid && !rsp_ready.

## Timing
- Reset values, applied asynchronously while rst is high:
  - rsp_valid=0, rsp_result=0, rsp_zf=0, rsp_sf=0, rsp_of=0, rsp_id=0.
  - last_id=1, so requester 0 wins the first tie.
  - reqN_ready=0 while rst is high.
- Latency: accept in cycle T → rsp_valid and data visible after edge T+1 (one cycle). Throughput is 1/cycle while rsp_ready stays high.
- reqN_ready depends combinationally on reqN_valid, rsp_valid, rsp_ready and last_id. It has no path from operand inputs.
- Starvation bound: a continuously valid requester is accepted within 2 accepts (the other requester's accept, then its own), given rsp_ready is eventually asserted.
- Reset mid-operation: the held result is lost and rsp_valid=0. Requesters must re-present operations. No partial state survives.

## Test plan
- Sub overflow, req0 alone: a=0x7FFF_FFFF_FFFF_FFFF, b=0x8000_0000_0000_0000, fun=1 → next cycle rsp_result=0xFFFF_FFFF_FFFF_FFFF, of=1, sf=1, zf=0, rsp_id=0.
- Zero and add overflow:
  - a=b=0x8000_0000_0000_0000, fun=1 → result 0, zf=1, of=0.
  - Same operands with fun=0 → result 0, zf=1, of=1.
- Round-robin: both requesters valid for 4 cycles with rsp_ready=1, req0 fun=0 a=5 b=14, req1 fun=3 a=5 b=14 → rsp_id sequence 0,1,0,1, results 19, 11, 19, 11. Exactly one ready per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after the first accept → both readies are low, rsp_* are held. Raise rsp_ready → the queued request is accepted in the same cycle, and the next result appears one cycle later with no bubble.
- Logic ops: a=0xF0F0…F0, b=0xFF00…FF00, fun=2 → 0xF000…F000, of=0, sf=1. fun=3 → 0x0FF0…0FF0, sf=0.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 → rsp_valid drops immediately and all outputs are 0. After release, a tied request goes to requester 0 first.
